// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/exec/mem/writeback control FSM owning the PC and instruction register
module instr_sequencer #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int CYC_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  input  logic                   dec_reg_write,
  input  logic                   dec_mem_read,
  input  logic                   dec_mem_write,
  input  logic                   dec_branch,
  input  logic                   dec_halt,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ready,
  output logic                   rf_we,
  output logic                   busy,
  output logic                   done,
  output logic [CYC_WIDTH-1:0]   cycle_count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic [PC_WIDTH-1:0] pc, pc_upd;
  logic is_store, wb_we, launch;
  assign launch = (state == IDLE || state == HALT) && start;
  assign pc_upd = (dec_branch && branch_taken) ? branch_target : pc + PC_WIDTH'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT: state_nx = start ? FETCH : state;
      FETCH:      state_nx = EXEC;
      EXEC:       state_nx = dec_halt ? HALT : (dec_mem_read || dec_mem_write) ? MEM : WB;
      MEM:        state_nx = !dmem_ready ? MEM : is_store ? FETCH : WB;
      WB:         state_nx = FETCH;
      default:    state_nx = IDLE;
    endcase
  end
  // Decoder control bits are captured in EXEC so the strobes depend only on registered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      cycle_count <= '0;
      is_store    <= 1'b0;
      wb_we       <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        pc          <= start_pc;
        cycle_count <= '0;
      end else if (busy && cycle_count != '1) cycle_count <= cycle_count + CYC_WIDTH'(1);
      if (state == FETCH) instr <= imem_rdata;
      if (state == EXEC) begin
        is_store <= dec_mem_write;
        wb_we    <= dec_reg_write;
      end
      if (state == WB || (state == MEM && dmem_ready && is_store)) pc <= pc_upd;
    end
  end
  assign imem_addr = pc;
  assign busy      = state == FETCH || state == EXEC || state == MEM || state == WB;
  assign done      = state == HALT;
  assign dmem_req  = state == MEM;
  assign dmem_we   = state == MEM && is_store;
  assign rf_we     = state == WB && wb_we;
endmodule
